lram_rom_reader: RTL and testbench
==================================

# lram_rom_reader

Command-driven read sequencer that sits directly upstream of the 64x8 LUTRAM ROM (`main`). It walks a contiguous address range, with wrap-around, and presents the returned bytes as a valid/ready stream with a last-beat marker. A credit-limited output FIFO means downstream backpressure never drops a ROM word. This block replaces the free-running address counter used around the ROM today.

## Interface
- `AW`, default 6: ROM address width; the ROM holds 2^AW words.
- `DW`, default 8: ROM data width.
- `READ_LAT`, default 1: cycles from `rom_addr` presented to `rom_data` valid. Legal values are 1 and 2.
- `clock`, in, 1: clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE and when `reset` is low.
- `cmd_base`, in, AW: start address.
- `cmd_len`, in, AW+1: word count, 0..2^AW.
- `rom_addr`, out, AW: address to the ROM.
- `rom_data`, in, DW: ROM read data, READ_LAT cycles after its address.
- `out_valid`, out, 1: stream beat available.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_data`, out, DW: beat data.
- `out_last`, out, 1: final beat of the command.
- `busy`, out, 1: state is not IDLE.

## Operation
FSM states are IDLE, RUN and DRAIN.
- **IDLE:**
  - The command handshake is `cmd_valid && cmd_ready`. On it, latch `addr=cmd_base` and `remaining=cmd_len`.
  - If `cmd_len==0`, consume the command, produce no beats and stay in IDLE. Otherwise go to RUN.
- **RUN:**
  - A read issues in any cycle where `count + inflight - pop < DEPTH`.
    - `DEPTH = READ_LAT+1`.
    - `count` is the FIFO occupancy.
    - `inflight` is reads issued but not yet captured.
    - `pop = out_valid && out_ready`.
  - On issue: `rom_addr` carries `addr` for that cycle; then `addr <= addr+1` modulo 2^AW (0x3F wraps to 0x00) and `remaining` decrements.
  - The issue that brings `remaining` to 0 is tagged last, and the FSM goes to DRAIN.
  - `rom_addr` holds its value in cycles with no issue.
- **Capture:** a shift register of READ_LAT stages carries the issue flag and last tag. When a stage exits, `rom_data` and the tag are written into the FIFO. `inflight` updates from the issue and capture events of the same cycle.
- **DRAIN:** go to IDLE in the cycle the last-tagged beat is popped. `inflight` and `count` are 0 at that point.
- **Output:** `out_valid` equals FIFO non-empty. `out_data` and `out_last` come from the FIFO head and stay stable while `out_valid && !out_ready`.
- **Overflow:** impossible by construction. The bench asserts `count <= DEPTH`.
- **Width rules:** `remaining` and `count` are AW+1 bits; address arithmetic is AW bits with natural wrap.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_last=0`, `out_data=0`, `rom_addr=0`.
  - `busy=0`, `cmd_ready=0` while `reset` is high.
  - FIFO empty, pipeline cleared, FSM in IDLE.
- **Reset mid-operation:** flushes all in-flight and buffered beats. No beat appears after reset.
- **Command-to-data latency:** take the handshake edge as the end of cycle 0. The first issue is in cycle 1, and `out_valid` first rises in cycle 2+READ_LAT.
- **Throughput:** with `out_ready` held high, one beat per cycle. N words finish in cycle N+1+READ_LAT.
- **Backpressure:** when `out_ready` goes low, issue stops within the same cycle once credits run out. Resuming `out_ready` resumes issue in that same cycle through pop-credit.
- **Back-to-back commands:** `cmd_ready` rises the cycle after the last pop. Commands never overlap.

## Configuration
- **`LRAM_ROM_READER_CSUM_EN` defined:** adds outputs `csum` (DW) and `csum_valid` (1).
  - `csum` is cleared on command accept, and becomes `csum ^ out_data` on every pop.
  - `csum_valid` pulses for one cycle, the cycle after the last-tagged pop, with the final XOR on `csum`.
  - Both reset to 0.
- **Undefined:** both ports and all checksum logic are absent. All other behaviour is identical.

## Test plan
Bench ROM model: READ_LAT=1, word at address a equals a+8'h10.
- **Single word:** base=0x05, len=1, `out_ready`=1 -> one beat, data 0x15, `out_last`=1, `out_valid` first in cycle 3. Then `busy` falls and `cmd_ready` rises.
- **Streaming with wrap:** base=0x3E, len=4, `out_ready`=1 -> 0x4E, 0x4F, 0x10, 0x11 on consecutive cycles; last on 0x11.
- **Backpressure:** base=0x00, len=8, `out_ready` toggled 1,0,0,1,... -> exactly 0x10..0x17 in order, no loss or duplicate, `count` never above 2.
- **Zero length and full range:**
  - len=0 -> command accepted, no beats, `busy` stays 0.
  - len=64, base=0 -> 64 beats, last data 0x4F.
- **Reset mid-stream:** reset asserted after 3 beats of a len=10 command -> `out_valid`=0 the cycle after, no further beats. A new command (base 0x20, len 2) after reset yields 0x30, 0x31.
- **Checksum (with `LRAM_ROM_READER_CSUM_EN`):** base=0x00, len=4 -> `csum_valid` one cycle with `csum`=0x10^0x11^0x12^0x13=0x00. For base=0x01, len=3, `csum`=0x11^0x12^0x13=0x10.

Source files
------------

// File: rtl/lram_rom_reader_if.sv
// Command and output-stream bundle for lram_rom_reader.
// master: command source / beat sink; slave: the reader itself.
interface lram_rom_reader_if #(
   parameter int AW = 6,
   parameter int DW = 8
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_base;
   logic [AW:0]   cmd_len;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output cmd_valid, cmd_base, cmd_len, out_ready,
      input  cmd_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  cmd_valid, cmd_base, cmd_len, out_ready,
      output cmd_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/lram_rom_reader.sv
// ROM read sequencer: walks a wrapping address range and streams the words (optional checksum: LRAM_ROM_READER_CSUM_EN).
// Latency: first beat valid 2+READ_LAT cycles after the command handshake, then one beat per cycle.
// Backpressure: reads issue only against output-FIFO credit, so a stalled sink never loses a ROM word.
module lram_rom_reader #(
   parameter int AW       = 6,
   parameter int DW       = 8,
   parameter int READ_LAT = 1
) (
   input  logic            clock,
   input  logic            reset,
   lram_rom_reader_if.slave bus,
   output logic [AW-1:0]   rom_addr,
   input  logic [DW-1:0]   rom_data,
   output logic            busy
`ifdef LRAM_ROM_READER_CSUM_EN
   ,
   output logic [DW-1:0]   csum,
   output logic            csum_valid
`endif
);
   localparam int DEPTH = READ_LAT + 1;
   localparam int PW    = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_next;

   logic [AW-1:0]       addr, rom_addr_q;
   logic [AW:0]         remaining, count;
   logic [1:0]          inflight;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [DW-1:0]       fifo_data [DEPTH];
   logic                fifo_last [DEPTH];
   logic [READ_LAT-1:0] stg_vld, stg_last;
   logic                accept, issue, issue_last, cap, cap_last, pop;
   int                  credit_use;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop           = bus.out_valid && bus.out_ready;
   assign cap           = stg_vld[READ_LAT-1];
   assign cap_last      = stg_last[READ_LAT-1];
   // Credit counts words already buffered plus words still in the ROM pipe; a pop frees one this cycle.
   assign credit_use    = int'(count) + int'(inflight) - int'(pop);
   assign rom_addr      = issue ? addr : rom_addr_q;
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
   assign bus.out_last  = bus.out_valid ? fifo_last[rd_ptr] : 1'b0;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      bus.cmd_ready = (state == IDLE) && !reset;
      busy          = (state != IDLE) && !reset;
      accept        = bus.cmd_valid && bus.cmd_ready;
      issue         = (state == RUN) && !reset && (credit_use < DEPTH);
      issue_last    = issue && (remaining == (AW+1)'(1));
      case (state)
         IDLE:    if (accept && (bus.cmd_len != '0)) state_next = RUN;
         RUN:     if (issue_last) state_next = DRAIN;
         DRAIN:   if (pop && bus.out_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr       <= '0;
         rom_addr_q <= '0;
         remaining  <= '0;
         count      <= '0;
         inflight   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         stg_vld    <= '0;
         stg_last   <= '0;
      end else begin
         if (accept) begin
            addr      <= bus.cmd_base;
            remaining <= bus.cmd_len;
         end
         if (issue) begin
            rom_addr_q <= addr;
            addr       <= addr + AW'(1);
            remaining  <= remaining - (AW+1)'(1);
         end
         stg_vld[0]  <= issue;
         stg_last[0] <= issue_last;
         for (int i = 1; i < READ_LAT; i++) begin
            stg_vld[i]  <= stg_vld[i-1];
            stg_last[i] <= stg_last[i-1];
         end
         inflight <= inflight + 2'(issue) - 2'(cap);
         count    <= count + (AW+1)'(cap) - (AW+1)'(pop);
         if (cap) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge clock) begin
      if (cap && !reset) begin
         fifo_data[wr_ptr] <= rom_data;
         fifo_last[wr_ptr] <= cap_last;
      end
   end

`ifdef LRAM_ROM_READER_CSUM_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         csum       <= '0;
         csum_valid <= 1'b0;
      end else begin
         csum_valid <= pop && bus.out_last;
         if (accept)   csum <= '0;
         else if (pop) csum <= csum ^ bus.out_data;
      end
   end
`endif
endmodule

// File: tb/tb_lram_rom_reader.sv
// Bench for lram_rom_reader: queue-based beat model plus directed latency/data literals and random traffic.
// Latency: samples outputs on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: out_ready driven by a mode-selected process (always, random, 1-0-0 pattern, never).
module tb_lram_rom_reader;
   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic       clock;
   logic       reset;
   logic [5:0] rom_addr;
   logic [7:0] rom_data;
   logic [5:0] rom_q;
   logic       busy;
`ifdef LRAM_ROM_READER_CSUM_EN
   logic [7:0] csum;
   logic       csum_valid;
   logic [7:0] m_csum;
   bit         pend_csum;
   bit         post_csum_vld;
   logic [7:0] post_csum;
`endif

   int         checks = 0;
   int         failures = 0;
   int         rdy_mode = 3;
   int         pcnt = 0;
   beat_t      exp_q[$];
   logic [7:0] got_q[$];
   bit         got_last;
   int         first_cyc, last_cyc;
   bit         post_busy, post_rdy;
   bit         stall_prev = 0;
   logic [7:0] prev_d;
   logic       prev_l;

   lram_rom_reader_if #(.AW(6), .DW(8)) bus ();

   lram_rom_reader #(.AW(6), .DW(8), .READ_LAT(1)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy)
`ifdef LRAM_ROM_READER_CSUM_EN
      ,
      .csum       (csum),
      .csum_valid (csum_valid)
`endif
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // ROM model: one-cycle registered read, word a holds a + 0x10.
   always @(posedge clock) rom_q <= rom_addr;
   assign rom_data = {2'b00, rom_q} + 8'h10;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      bus.out_ready = 0;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0: bus.out_ready = 1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               bus.out_ready = (pcnt % 3 == 0);
               pcnt++;
            end
            default: bus.out_ready = 0;
         endcase
      end
   end

   // Reference model and per-cycle compare.
   always @(negedge clock) begin
      beat_t e;
      if (reset) begin
         chk("cmd_ready_in_reset", bus.cmd_ready, 0);
         chk("busy_in_reset", busy, 0);
         exp_q.delete();
         stall_prev = 0;
`ifdef LRAM_ROM_READER_CSUM_EN
         pend_csum = 0;
`endif
      end else begin
         chk("cmd_ready", bus.cmd_ready, exp_q.size() == 0);
         chk("busy", busy, exp_q.size() != 0);
         chk("fifo_count_le_depth", dut.count <= 2, 1);
         if (exp_q.size() == 0) chk("no_beat_when_idle", bus.out_valid, 0);
         if (stall_prev) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, prev_d);
            chk("stall_last", bus.out_last, prev_l);
         end
`ifdef LRAM_ROM_READER_CSUM_EN
         if (pend_csum) begin
            chk("csum_valid", csum_valid, 1);
            chk("csum", csum, m_csum);
         end else begin
            chk("csum_valid_idle", csum_valid, 0);
         end
         pend_csum = 0;
`endif
         if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", bus.out_data, e.d);
            chk("beat_last", bus.out_last, e.l);
`ifdef LRAM_ROM_READER_CSUM_EN
            m_csum = m_csum ^ e.d;
            if (e.l) pend_csum = 1;
`endif
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            for (int i = 0; i < int'(bus.cmd_len); i++) begin
               e.d = 8'(((int'(bus.cmd_base) + i) % 64) + 16);
               e.l = (i == int'(bus.cmd_len) - 1);
               exp_q.push_back(e);
            end
`ifdef LRAM_ROM_READER_CSUM_EN
            m_csum = 8'h00;
`endif
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_d     = bus.out_data;
         prev_l     = bus.out_last;
      end
   end

   task automatic send_cmd(input logic [5:0] base, input logic [6:0] len);
      int n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!bus.cmd_ready && n < 1000);
      chk("cmd_ready_wait", bus.cmd_ready, 1);
      bus.cmd_base  = base;
      bus.cmd_len   = len;
      bus.cmd_valid = 1;
      @(posedge clock);
      #1;
      bus.cmd_valid = 0;
   endtask

   // Handshake, then record beats with cycle indices (handshake edge ends cycle 0).
   task automatic run_cmd(input logic [5:0] base, input logic [6:0] len, input int budget);
      int cyc = 0;
      bit done;
      got_q.delete();
      got_last  = 0;
      first_cyc = -1;
      last_cyc  = -1;
      send_cmd(base, len);
      done = (len == 0);
      while (!done && cyc < budget) begin
         @(negedge clock);
         cyc++;
         if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_last = bus.out_last;
            last_cyc = cyc;
            if (bus.out_last) done = 1;
         end
      end
      chk("cmd_completes", done, 1);
      @(negedge clock);
      post_busy = busy;
      post_rdy  = bus.cmd_ready;
`ifdef LRAM_ROM_READER_CSUM_EN
      post_csum_vld = csum_valid;
      post_csum     = csum;
`endif
   endtask

   initial begin
      int pops;
      reset = 1;
      bus.cmd_valid = 0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);

      rdy_mode = 0;
      run_cmd(6'h05, 7'd1, 200);
      chk("single_nbeats", got_q.size(), 1);
      if (got_q.size() == 1) chk("single_data", got_q[0], 8'h15);
      chk("single_last", got_last, 1);
      chk("single_first_valid_cyc", first_cyc, 3);
      chk("single_post_busy", post_busy, 0);
      chk("single_post_cmd_ready", post_rdy, 1);

      run_cmd(6'h3E, 7'd4, 200);
      chk("wrap_nbeats", got_q.size(), 4);
      if (got_q.size() == 4) begin
         chk("wrap_d0", got_q[0], 8'h4E);
         chk("wrap_d1", got_q[1], 8'h4F);
         chk("wrap_d2", got_q[2], 8'h10);
         chk("wrap_d3", got_q[3], 8'h11);
      end
      chk("wrap_first_cyc", first_cyc, 3);
      chk("wrap_last_cyc", last_cyc, 6);

      rdy_mode = 2;
      pcnt = 0;
      run_cmd(6'h00, 7'd8, 500);
      chk("bp_nbeats", got_q.size(), 8);
      foreach (got_q[i]) chk("bp_data", got_q[i], 8'h10 + 8'(i));

      rdy_mode = 0;
      run_cmd(6'h12, 7'd0, 10);
      chk("zero_nbeats", got_q.size(), 0);
      chk("zero_busy", post_busy, 0);
      chk("zero_cmd_ready", post_rdy, 1);

      run_cmd(6'h00, 7'd64, 500);
      chk("full_nbeats", got_q.size(), 64);
      if (got_q.size() == 64) chk("full_last_data", got_q[63], 8'h4F);
      chk("full_last_cyc", last_cyc, 66);

`ifdef LRAM_ROM_READER_CSUM_EN
      run_cmd(6'h00, 7'd4, 200);
      chk("csum_a_valid", post_csum_vld, 1);
      chk("csum_a_value", post_csum, 8'h00);
      run_cmd(6'h01, 7'd3, 200);
      chk("csum_b_valid", post_csum_vld, 1);
      chk("csum_b_value", post_csum, 8'h10);
`endif

      // Reset after three beats of a ten-word command.
      send_cmd(6'h00, 7'd10);
      pops = 0;
      for (int n = 0; n < 200 && pops < 3; n++) begin
         @(negedge clock);
         if (bus.out_valid && bus.out_ready) pops++;
      end
      chk("mid_reset_three_pops", pops, 3);
      rdy_mode = 3;
      @(posedge clock);
      #1 reset = 1;
      @(posedge clock);
      @(negedge clock);
      chk("mid_reset_out_valid", bus.out_valid, 0);
      rdy_mode = 0;
      @(posedge clock);
      #1 reset = 0;
      repeat (10) begin
         @(negedge clock);
         chk("post_reset_no_beat", bus.out_valid, 0);
      end
      run_cmd(6'h20, 7'd2, 200);
      chk("after_reset_nbeats", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("after_reset_d0", got_q[0], 8'h30);
         chk("after_reset_d1", got_q[1], 8'h31);
      end

      rdy_mode = 1;
      for (int k = 0; k < 30; k++) begin
         logic [6:0] len;
         case ($urandom_range(0, 3))
            0:       len = 7'($urandom_range(0, 2));
            1:       len = 7'd64;
            default: len = 7'($urandom_range(1, 64));
         endcase
         run_cmd(6'($urandom_range(0, 63)), len, 2000);
      end

      rdy_mode = 0;
      repeat (5) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
